// File: rtl/soc_glue_pkg.sv
// rtl/soc_glue_pkg.sv - shared offsets, error codes, APB state type and helpers for the SoC glue register block
package soc_glue_pkg;

  localparam logic [7:0] OFF_ID         = 8'h00;
  localparam logic [7:0] OFF_STATUS     = 8'h04;
  localparam logic [7:0] OFF_ERR_STATUS = 8'h08;
  localparam logic [7:0] OFF_ERR_CODE   = 8'h0C;
  localparam logic [7:0] OFF_IRQ_MASK   = 8'h10;
  localparam logic [7:0] OFF_IRQ_PEND   = 8'h14;
  localparam logic [7:0] OFF_SCRATCH    = 8'h18;
  localparam logic [7:0] OFF_LOCK       = 8'h1C;

  localparam logic [3:0] ERR_CODE_ADDR_DECODE = 4'h1;
  localparam logic [3:0] ERR_CODE_TIMEOUT     = 4'h2;
  localparam logic [3:0] ERR_CODE_ACCESS      = 4'h5;
  localparam logic [3:0] ERR_CODE_SECURITY    = 4'h6;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} apb_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    return res;
  endfunction

  // Lowest-numbered event bit decides the captured code.
  function automatic logic [3:0] err_code_of(input logic [3:0] ev);
    if (ev[0]) return ERR_CODE_ADDR_DECODE;
    else if (ev[1]) return ERR_CODE_TIMEOUT;
    else if (ev[2]) return ERR_CODE_ACCESS;
    else if (ev[3]) return ERR_CODE_SECURITY;
    return 4'h0;
  endfunction

endpackage

// File: rtl/soc_glue_apb_regs_if.sv
// rtl/soc_glue_apb_regs_if.sv - APB4 bus bundle with requester (master) and completer (slave) views
interface soc_glue_apb_regs_if #(parameter int ADDR_W = 12);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (output paddr, psel, penable, pwrite, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata, pstrb,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/soc_glue_apb_fsm.sv
// rtl/soc_glue_apb_fsm.sv - APB completer handshake: wait states, registered response and write-commit strobe
module soc_glue_apb_fsm
  import soc_glue_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic        access_err,
  input  logic [31:0] rdata_next,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        commit
);

  apb_state_e state;
  logic [2:0] wait_cnt;
  logic       go_resp;

  // pready rises WAIT_CYCLES + 2 cycles after the setup-phase cycle.
  assign go_resp = psel && (((state == SETUP) && (WAIT_CYCLES == 0)) ||
                            ((state == WAIT) && (wait_cnt == 3'd1)));

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      pready   <= 1'b0;
      prdata   <= '0;
      pslverr  <= 1'b0;
      commit   <= 1'b0;
    end else begin
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      commit  <= 1'b0;
      case (state)
        IDLE: if (psel && !penable) state <= SETUP;
        SETUP: begin
          if (!psel) state <= IDLE;
          else if (go_resp) state <= RESP;
          else begin
            wait_cnt <= 3'(WAIT_CYCLES);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!psel) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
            if (go_resp) state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        pready  <= 1'b1;
        pslverr <= access_err;
        prdata  <= (pwrite || access_err) ? 32'h0 : rdata_next;
        commit  <= pwrite && !access_err;
      end
    end
  end

endmodule

// File: rtl/soc_glue_apb_regs.sv
// rtl/soc_glue_apb_regs.sv - SoC glue APB register block (error capture, status, IRQ mask/pending, scratch); SOC_GLUE_REGS_LOCK_EN adds the LOCK register
module soc_glue_apb_regs
  import soc_glue_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          NUM_IRQ     = 24,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h5947_0001
) (
  input  logic                 clk_sys,
  input  logic                 rst_sys_n,
  soc_glue_apb_regs_if.slave   apb,
  input  logic [3:0]           err_event,
  input  logic                 boot_done,
  input  logic                 system_ready,
  input  logic                 init_done,
  input  logic                 pll_lock,
  input  logic [NUM_IRQ-1:0]   irq_raw,
  output logic                 irq_out,
  output logic                 err_irq
);

  logic [ADDR_W-1:0]  addr_w;
  logic [31:0]        rdata_next;
  logic               access_err;
  logic               commit;
  logic               wr_en;
  logic [3:0]         err_status;
  logic [3:0]         err_status_next;
  logic [3:0]         err_clr;
  logic               err_code_valid;
  logic [3:0]         err_code;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [31:0]        scratch;
  logic               lock;

  assign addr_w = apb.paddr & ~ADDR_W'(3);
  assign wr_en  = commit && apb.psel;

  always_comb begin
    rdata_next = '0;
    access_err = 1'b0;
    case (addr_w)
      ADDR_W'(OFF_ID): begin
        rdata_next = ID_VALUE;
        access_err = apb.pwrite;
      end
      ADDR_W'(OFF_STATUS): begin
        rdata_next = {28'h0, pll_lock, init_done, system_ready, boot_done};
        access_err = apb.pwrite;
      end
      ADDR_W'(OFF_ERR_STATUS): rdata_next = {28'h0, err_status};
      ADDR_W'(OFF_ERR_CODE): begin
        rdata_next = {err_code_valid, 27'h0, err_code};
        access_err = apb.pwrite;
      end
      ADDR_W'(OFF_IRQ_MASK): begin
        rdata_next = 32'(irq_mask);
        access_err = apb.pwrite && lock;
      end
      ADDR_W'(OFF_IRQ_PEND): begin
        rdata_next = 32'(irq_raw & irq_mask);
        access_err = apb.pwrite;
      end
      ADDR_W'(OFF_SCRATCH): begin
        rdata_next = scratch;
        access_err = apb.pwrite && lock;
      end
`ifdef SOC_GLUE_REGS_LOCK_EN
      ADDR_W'(OFF_LOCK): begin
        rdata_next = {31'h0, lock};
        access_err = apb.pwrite && lock;
      end
`endif
      default: access_err = 1'b1;
    endcase
  end

  // A new event on the same edge as a W1C clear keeps its bit set.
  always_comb begin
    err_clr = '0;
    if (wr_en && (addr_w == ADDR_W'(OFF_ERR_STATUS)) && apb.pstrb[0])
      err_clr = apb.pwdata[3:0];
    err_status_next = (err_status & ~err_clr) | err_event;
  end

  soc_glue_apb_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
    .clk_sys    (clk_sys),
    .rst_sys_n  (rst_sys_n),
    .psel       (apb.psel),
    .penable    (apb.penable),
    .pwrite     (apb.pwrite),
    .access_err (access_err),
    .rdata_next (rdata_next),
    .pready     (apb.pready),
    .prdata     (apb.prdata),
    .pslverr    (apb.pslverr),
    .commit     (commit)
  );

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      irq_out        <= 1'b0;
      err_irq        <= 1'b0;
      err_status     <= '0;
      err_code_valid <= 1'b0;
      err_code       <= '0;
      irq_mask       <= '0;
      scratch        <= '0;
    end else begin
      irq_out    <= |(irq_raw & irq_mask);
      err_irq    <= |err_status;
      err_status <= err_status_next;
      if (err_status_next == 4'h0) begin
        err_code_valid <= 1'b0;
        err_code       <= '0;
      end else if (!err_code_valid && (|err_event)) begin
        err_code_valid <= 1'b1;
        err_code       <= err_code_of(err_event);
      end
      if (wr_en) begin
        case (addr_w)
          ADDR_W'(OFF_IRQ_MASK):
            irq_mask <= NUM_IRQ'(apply_strb(32'(irq_mask), apb.pwdata, apb.pstrb));
          ADDR_W'(OFF_SCRATCH):
            scratch <= apply_strb(scratch, apb.pwdata, apb.pstrb);
          default: ;
        endcase
      end
    end
  end

`ifdef SOC_GLUE_REGS_LOCK_EN
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) lock <= 1'b0;
    else if (wr_en && (addr_w == ADDR_W'(OFF_LOCK)) && apb.pstrb[0] && apb.pwdata[0])
      lock <= 1'b1;
  end
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_soc_glue_apb_regs.sv
// tb/tb_soc_glue_apb_regs.sv - self-checking bench: vector table, directed corner sequences, random traffic vs reference model
module tb_soc_glue_apb_regs;
  import soc_glue_pkg::*;

  localparam int          ADDR_W      = 12;
  localparam int          NUM_IRQ     = 24;
  localparam int          WAIT_CYCLES = 1;
  localparam logic [31:0] ID_VALUE    = 32'h5947_0001;

  logic               clk_sys = 1'b0;
  logic               rst_sys_n = 1'b0;
  logic [3:0]         err_event = '0;
  logic               boot_done = 1'b0, system_ready = 1'b0, init_done = 1'b0, pll_lock = 1'b0;
  logic [NUM_IRQ-1:0] irq_raw = '0;
  logic               irq_out, err_irq;

  soc_glue_apb_regs_if #(.ADDR_W(ADDR_W)) apb ();

  soc_glue_apb_regs #(
    .ADDR_W(ADDR_W), .NUM_IRQ(NUM_IRQ), .WAIT_CYCLES(WAIT_CYCLES), .ID_VALUE(ID_VALUE)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .apb          (apb),
    .err_event    (err_event),
    .boot_done    (boot_done),
    .system_ready (system_ready),
    .init_done    (init_done),
    .pll_lock     (pll_lock),
    .irq_raw      (irq_raw),
    .irq_out      (irq_out),
    .err_irq      (err_irq)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  logic [NUM_IRQ-1:0] m_mask;
  logic [31:0]        m_scratch;
  logic [3:0]         m_err_status;
  logic               m_code_valid;
  logic [3:0]         m_code;
  logic               m_lock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [11:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] er, input logic ee);
    vec_t v;
    v.addr = a; v.wr = w; v.wdata = d; v.strb = s; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // ev_at_resp is pulsed on err_event across the commit edge of this transfer.
  task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [3:0] ev_at_resp,
                          output logic [31:0] rdata, output logic slverr, output int lat);
    logic got;
    got = 1'b0; rdata = '0; slverr = 1'b0; lat = 0;
    @(posedge clk_sys); #1;
    apb.paddr = addr; apb.pwrite = wr; apb.pwdata = wdata; apb.pstrb = strb;
    apb.psel = 1'b1; apb.penable = 1'b0;
    @(posedge clk_sys); #1;
    apb.penable = 1'b1;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk_sys);
      if (apb.pready) begin
        got = 1'b1; lat = i; rdata = apb.prdata; slverr = apb.pslverr;
        err_event = ev_at_resp;
      end else begin
        @(posedge clk_sys); #1;
      end
    end
    chk("pready_seen", 32'(got), 32'd1);
    @(posedge clk_sys); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; err_event = '0;
  endtask

  task automatic pulse_event(input logic [3:0] ev);
    @(posedge clk_sys); #1 err_event = ev;
    @(posedge clk_sys); #1 err_event = '0;
  endtask

  task automatic do_reset();
    rst_sys_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;
    m_mask = '0; m_scratch = '0; m_err_status = '0; m_code_valid = 1'b0; m_code = '0; m_lock = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] bm;
    for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{st[i]}};
    return (old & ~bm) | (wd & bm);
  endfunction

  task automatic model_event(input logic [3:0] ev);
    logic [3:0] codes [4];
    codes[0] = 4'h1; codes[1] = 4'h2; codes[2] = 4'h5; codes[3] = 4'h6;
    if (ev != 4'h0) begin
      m_err_status = m_err_status | ev;
      if (!m_code_valid) begin
        m_code_valid = 1'b1;
        for (int b = 3; b >= 0; b--) if (ev[b]) m_code = codes[b];
      end
    end
  endtask

  task automatic model_access(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                              input logic [3:0] st, output logic [31:0] er, output logic ee);
    er = '0; ee = 1'b0;
    case (addr[11:2])
      10'd0: if (wr) ee = 1'b1; else er = ID_VALUE;
      10'd1: if (wr) ee = 1'b1; else er = {28'h0, pll_lock, init_done, system_ready, boot_done};
      10'd2: if (wr) begin
               if (st[0]) m_err_status = m_err_status & ~wd[3:0];
               if (m_err_status == 4'h0) begin m_code_valid = 1'b0; m_code = '0; end
             end else er = {28'h0, m_err_status};
      10'd3: if (wr) ee = 1'b1; else er = {m_code_valid, 27'h0, m_code};
      10'd4: if (wr) begin
               if (m_lock) ee = 1'b1; else m_mask = NUM_IRQ'(merge(32'(m_mask), wd, st));
             end else er = 32'(m_mask);
      10'd5: if (wr) ee = 1'b1; else er = 32'(irq_raw & m_mask);
      10'd6: if (wr) begin
               if (m_lock) ee = 1'b1; else m_scratch = merge(m_scratch, wd, st);
             end else er = m_scratch;
`ifdef SOC_GLUE_REGS_LOCK_EN
      10'd7: if (wr) begin
               if (m_lock) ee = 1'b1; else if (st[0] && wd[0]) m_lock = 1'b1;
             end else er = {31'h0, m_lock};
`endif
      default: ee = 1'b1;
    endcase
    if (ee || wr) er = '0;
  endtask

  initial begin
    logic [31:0] rd, er, addr_rnd;
    logic        se, ee, wr;
    logic [3:0]  st, ev;
    int          lat, k;

    apb.paddr = '0; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.pwdata = '0; apb.pstrb = '0;

    #12;
    chk("rst_pready", 32'(apb.pready), 32'd0);
    chk("rst_prdata", apb.prdata, 32'd0);
    chk("rst_pslverr", 32'(apb.pslverr), 32'd0);
    chk("rst_irq_out", 32'(irq_out), 32'd0);
    chk("rst_err_irq", 32'(err_irq), 32'd0);
    do_reset();
    {pll_lock, init_done, system_ready, boot_done} = 4'b1011;

    vecs.push_back(mk(12'h000, 1'b0, 32'h0, 4'hF, ID_VALUE, 1'b0));
    vecs.push_back(mk(12'h010, 1'b1, 32'h0000_0005, 4'b0001, 32'h0, 1'b0));
    vecs.push_back(mk(12'h010, 1'b0, 32'h0, 4'hF, 32'h0000_0005, 1'b0));
    vecs.push_back(mk(12'h018, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(12'h018, 1'b1, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0));
    vecs.push_back(mk(12'h01A, 1'b0, 32'h0, 4'hF, 32'h12BB_56DD, 1'b0));
    vecs.push_back(mk(12'h040, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1));
    vecs.push_back(mk(12'h004, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1));
    vecs.push_back(mk(12'h004, 1'b0, 32'h0, 4'hF, 32'h0000_000B, 1'b0));
    vecs.push_back(mk(12'h000, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1));
    vecs.push_back(mk(12'h014, 1'b1, 32'h1, 4'hF, 32'h0, 1'b1));
    vecs.push_back(mk(12'h014, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(12'h008, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(12'h00C, 1'b1, 32'h1, 4'hF, 32'h0, 1'b1));
`ifdef SOC_GLUE_REGS_LOCK_EN
    vecs.push_back(mk(12'h01C, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0));
`else
    vecs.push_back(mk(12'h01C, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1));
`endif

    foreach (vecs[i]) begin
      apb_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, 4'h0, rd, se, lat);
      chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_pslverr", i), 32'(se), 32'(vecs[i].exp_err));
    end

    apb_xfer(12'h000, 1'b0, 32'h0, 4'hF, 4'h0, rd, se, lat);
    chk("latency_cycles", 32'(lat), 32'(2 + WAIT_CYCLES));

    @(posedge clk_sys); #1 irq_raw = 24'h000004;
    @(posedge clk_sys); #1;
    chk("irq_out_set", 32'(irq_out), 32'd1);
    apb_xfer(12'h014, 1'b0, 32'h0, 4'hF, 4'h0, rd, se, lat);
    chk("irq_pend_read", rd, 32'h4);
    irq_raw = '0;

    pulse_event(4'b0110);
    apb_xfer(12'h008, 1'b0, 32'h0, 4'hF, 4'h0, rd, se, lat);
    chk("err_status_6", rd, 32'h6);
    apb_xfer(12'h00C, 1'b0, 32'h0, 4'hF, 4'h0, rd, se, lat);
    chk("err_code_timeout", rd, 32'h8000_0002);
    chk("err_irq_set", 32'(err_irq), 32'd1);
    apb_xfer(12'h008, 1'b1, 32'hF, 4'hF, 4'h0, rd, se, lat);
    apb_xfer(12'h008, 1'b0, 32'h0, 4'hF, 4'h0, rd, se, lat);
    chk("err_status_w1c", rd, 32'h0);
    apb_xfer(12'h00C, 1'b0, 32'h0, 4'hF, 4'h0, rd, se, lat);
    chk("err_code_cleared", rd, 32'h0);
    chk("err_irq_clear", 32'(err_irq), 32'd0);

    pulse_event(4'b0001);
    apb_xfer(12'h008, 1'b1, 32'h1, 4'hF, 4'b0001, rd, se, lat);
    apb_xfer(12'h008, 1'b0, 32'h0, 4'hF, 4'h0, rd, se, lat);
    chk("set_beats_w1c", rd, 32'h1);
    apb_xfer(12'h008, 1'b1, 32'h1, 4'hF, 4'h0, rd, se, lat);
    apb_xfer(12'h008, 1'b0, 32'h0, 4'hF, 4'h0, rd, se, lat);
    chk("w1c_alone", rd, 32'h0);

    // Requester abandons a write during the wait state.
    @(posedge clk_sys); #1;
    apb.paddr = 12'h018; apb.pwrite = 1'b1; apb.pwdata = 32'h1111_1111; apb.pstrb = 4'hF;
    apb.psel = 1'b1; apb.penable = 1'b0;
    @(posedge clk_sys); #1 apb.penable = 1'b1;
    @(posedge clk_sys); #1 apb.psel = 1'b0; apb.penable = 1'b0;
    k = 0;
    repeat (4) begin @(negedge clk_sys); if (apb.pready) k++; end
    chk("abort_no_pready", 32'(k), 32'd0);
    apb_xfer(12'h018, 1'b0, 32'h0, 4'hF, 4'h0, rd, se, lat);
    chk("abort_no_write", rd, 32'h12BB_56DD);

    @(posedge clk_sys); #1;
    apb.paddr = 12'h018; apb.pwrite = 1'b1; apb.pwdata = 32'h2222_2222; apb.pstrb = 4'hF;
    apb.psel = 1'b1; apb.penable = 1'b0;
    @(posedge clk_sys); #1 apb.penable = 1'b1;
    @(posedge clk_sys); #1;
    chk("pre_rst_state", 32'(dut.u_fsm.state), 32'(WAIT));
    rst_sys_n = 1'b0;
    #1;
    chk("mid_rst_pready", 32'(apb.pready), 32'd0);
    chk("mid_rst_state", 32'(dut.u_fsm.state), 32'(IDLE));
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(posedge clk_sys); #1 rst_sys_n = 1'b1;
    apb_xfer(12'h018, 1'b0, 32'h0, 4'hF, 4'h0, rd, se, lat);
    chk("post_rst_scratch", rd, 32'h0);

`ifdef SOC_GLUE_REGS_LOCK_EN
    apb_xfer(12'h01C, 1'b1, 32'h1, 4'hF, 4'h0, rd, se, lat);
    chk("lock_set_err", 32'(se), 32'd0);
    apb_xfer(12'h018, 1'b1, 32'hDEAD_BEEF, 4'hF, 4'h0, rd, se, lat);
    chk("locked_scratch_err", 32'(se), 32'd1);
    apb_xfer(12'h018, 1'b0, 32'h0, 4'hF, 4'h0, rd, se, lat);
    chk("locked_scratch_val", rd, 32'h0);
    apb_xfer(12'h01C, 1'b1, 32'h0, 4'hF, 4'h0, rd, se, lat);
    chk("locked_lock_err", 32'(se), 32'd1);
    apb_xfer(12'h008, 1'b1, 32'hF, 4'hF, 4'h0, rd, se, lat);
    chk("locked_w1c_ok", 32'(se), 32'd0);
`endif

    do_reset();
    for (int it = 0; it < 120; it++) begin
      k = $urandom_range(0, 10);
      if (k < 8) addr_rnd = 32'(k * 4) | 32'($urandom_range(0, 3));
      else if (k == 8) addr_rnd = 32'h040;
      else addr_rnd = 32'($urandom_range(0, 4095));
      wr = 1'($urandom_range(0, 1));
      rd = $urandom;
      st = 4'($urandom_range(0, 15));
      {pll_lock, init_done, system_ready, boot_done} = 4'($urandom_range(0, 15));
      irq_raw = NUM_IRQ'($urandom);
      apb_xfer(addr_rnd[11:0], wr, rd, st, 4'h0, er, se, lat);
      model_access(addr_rnd[11:0], wr, rd, st, rd, ee);
      chk($sformatf("rnd%0d_prdata", it), er, rd);
      chk($sformatf("rnd%0d_pslverr", it), 32'(se), 32'(ee));
      chk($sformatf("rnd%0d_latency", it), 32'(lat), 32'(2 + WAIT_CYCLES));
      if ($urandom_range(0, 2) == 0) begin
        ev = 4'($urandom_range(1, 15));
        pulse_event(ev);
        model_event(ev);
      end
      @(posedge clk_sys); #1;
      chk($sformatf("rnd%0d_irq_out", it), 32'(irq_out), 32'(|(irq_raw & m_mask)));
      chk($sformatf("rnd%0d_err_irq", it), 32'(err_irq), 32'(|m_err_status));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
